// File: rtl/sap1_pkg.sv
// sap1_pkg: shared definitions for the SAP-1 controller/sequencer.
//   - opcode encodings (upper nibble of the instruction register)
//   - sequencer state encoding: one-hot T1..T6 in bits [5:0], HALT in bit 6,
//     all-zero for the post-reset idle state
//   - control-word bit indices and the per-state control words (the microcode)
package sap1_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    localparam int unsigned T_W = 6;

    typedef enum logic [T_W:0] {
        ST_IDLE = 7'b000_0000,
        ST_T1   = 7'b000_0001,
        ST_T2   = 7'b000_0010,
        ST_T3   = 7'b000_0100,
        ST_T4   = 7'b000_1000,
        ST_T5   = 7'b001_0000,
        ST_T6   = 7'b010_0000,
        ST_HALT = 7'b100_0000
    } seq_state_e;

    localparam int unsigned CW_W        = 12;
    localparam int unsigned CW_PC_INC   = 0;
    localparam int unsigned CW_PC_SEND  = 1;
    localparam int unsigned CW_MAR_LOAD = 2;
    localparam int unsigned CW_RAM_SEND = 3;
    localparam int unsigned CW_IR_LOAD  = 4;
    localparam int unsigned CW_IR_SEND  = 5;
    localparam int unsigned CW_A_LOAD   = 6;
    localparam int unsigned CW_A_SEND   = 7;
    localparam int unsigned CW_B_LOAD   = 8;
    localparam int unsigned CW_ALU_SEND = 9;
    localparam int unsigned CW_ALU_SUB  = 10;
    localparam int unsigned CW_OUT_LOAD = 11;

    typedef logic [CW_W-1:0] ctrl_word_t;

    localparam ctrl_word_t CW_ONE  = ctrl_word_t'(1);
    localparam ctrl_word_t CW_IDLE = '0;

    // Fetch
    localparam ctrl_word_t CW_T1 = (CW_ONE << CW_PC_SEND)  | (CW_ONE << CW_MAR_LOAD);
    localparam ctrl_word_t CW_T2 = (CW_ONE << CW_PC_INC);
    localparam ctrl_word_t CW_T3 = (CW_ONE << CW_RAM_SEND) | (CW_ONE << CW_IR_LOAD);

    // Execute
    localparam ctrl_word_t CW_MEM_ADDR = (CW_ONE << CW_IR_SEND)  | (CW_ONE << CW_MAR_LOAD);
    localparam ctrl_word_t CW_LDA_T5   = (CW_ONE << CW_RAM_SEND) | (CW_ONE << CW_A_LOAD);
    localparam ctrl_word_t CW_ARITH_T5 = (CW_ONE << CW_RAM_SEND) | (CW_ONE << CW_B_LOAD);
    localparam ctrl_word_t CW_ADD_T6   = (CW_ONE << CW_ALU_SEND) | (CW_ONE << CW_A_LOAD);
    localparam ctrl_word_t CW_SUB_T6   = CW_ADD_T6 | (CW_ONE << CW_ALU_SUB);
    localparam ctrl_word_t CW_OUT_T4   = (CW_ONE << CW_A_SEND)   | (CW_ONE << CW_OUT_LOAD);

    // Every enable that drives the shared bus
    localparam ctrl_word_t CW_SEND_MASK = (CW_ONE << CW_PC_SEND) | (CW_ONE << CW_RAM_SEND)
                                        | (CW_ONE << CW_IR_SEND) | (CW_ONE << CW_A_SEND)
                                        | (CW_ONE << CW_ALU_SEND);

endpackage

// File: rtl/ring_counter.sv
// ring_counter: one-hot T-state ring for the SAP-1 sequencer.
//   clk, rst      : clock, synchronous active-high reset (to the idle state)
//   en            : advance enable; low holds the current T-state
//   early_return  : when advancing, go to T1 instead of the next T-state
//   halt          : when advancing, go to HALT (held until reset)
//   state         : current state (one-hot T1..T6, HALT, or idle)
// The idle state is left for T1 on the first edge out of reset, independent
// of en, so the first instruction starts as soon as reset is released.
module ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       early_return,
    input  logic       halt,
    output seq_state_e state
);

    seq_state_e state_q;
    seq_state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_T1;
            ST_HALT: state_d = ST_HALT;
            ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6: begin
                if (en) begin
                    if (halt) begin
                        state_d = ST_HALT;
                    end else if (early_return) begin
                        state_d = ST_T1;
                    end else begin
                        case (state_q)
                            ST_T1:   state_d = ST_T2;
                            ST_T2:   state_d = ST_T3;
                            ST_T3:   state_d = ST_T4;
                            ST_T4:   state_d = ST_T5;
                            ST_T5:   state_d = ST_T6;
                            default: state_d = ST_T1;
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: SAP-1 controller/sequencer.
//   SKIP_NOP : 1 = return to T1 as soon as an instruction has no work left
//   clk, rst : clock, synchronous active-high reset
//   run      : clock enable; low freezes the ring and forces all enables to 0
//   debug    : qualifies the simulation-time bus-exclusivity check
//   opcode   : instruction register upper nibble, valid from T4
//   t_state  : one-hot T1..T6 (bit0 = T1), 0 in reset/idle/HALT
//   pc_inc .. out_load : datapath load/send enables (sole driver)
//   halted   : HLT has executed
// Enables are a Moore decode of the ring state and opcode, gated by run & ~rst.
module control_sequencer
    import sap1_pkg::*;
#(
    parameter bit SKIP_NOP = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic           debug,
    input  logic [3:0]     opcode,
    output logic [T_W-1:0] t_state,
    output logic           pc_inc,
    output logic           pc_send,
    output logic           mar_load,
    output logic           ram_send,
    output logic           ir_load,
    output logic           ir_send,
    output logic           a_load,
    output logic           a_send,
    output logic           b_load,
    output logic           alu_send,
    output logic           alu_sub,
    output logic           out_load,
    output logic           halted
);

    seq_state_e   state;
    logic [T_W:0] state_bits;
    logic         is_lda, is_add, is_sub, is_out, is_hlt, is_nop;
    logic         halt_req;
    logic         early_return;
    ctrl_word_t   word;
    ctrl_word_t   ctrl;

    assign is_lda = (opcode == OP_LDA);
    assign is_add = (opcode == OP_ADD);
    assign is_sub = (opcode == OP_SUB);
    assign is_out = (opcode == OP_OUT);
    assign is_hlt = (opcode == OP_HLT);
    assign is_nop = ~(is_lda | is_add | is_sub | is_out | is_hlt);

    assign halt_req = (state == ST_T4) & is_hlt;

    // The opcode is only trusted from T4, so a NOP cannot return before T4.
    assign early_return = SKIP_NOP & (((state == ST_T5) & is_lda)
                                    | ((state == ST_T4) & (is_out | is_nop)));

    ring_counter u_ring (
        .clk          (clk),
        .rst          (rst),
        .en           (run),
        .early_return (early_return),
        .halt         (halt_req),
        .state        (state)
    );

    always_comb begin
        word = CW_IDLE;
        case (state)
            ST_T1: word = CW_T1;
            ST_T2: word = CW_T2;
            ST_T3: word = CW_T3;
            ST_T4: begin
                if (is_lda | is_add | is_sub) begin
                    word = CW_MEM_ADDR;
                end else if (is_out) begin
                    word = CW_OUT_T4;
                end
            end
            ST_T5: begin
                if (is_lda) begin
                    word = CW_LDA_T5;
                end else if (is_add | is_sub) begin
                    word = CW_ARITH_T5;
                end
            end
            ST_T6: begin
                if (is_add) begin
                    word = CW_ADD_T6;
                end else if (is_sub) begin
                    word = CW_SUB_T6;
                end
            end
            default: word = CW_IDLE;
        endcase
    end

    assign ctrl = (run & ~rst) ? word : CW_IDLE;

    assign pc_inc   = ctrl[CW_PC_INC];
    assign pc_send  = ctrl[CW_PC_SEND];
    assign mar_load = ctrl[CW_MAR_LOAD];
    assign ram_send = ctrl[CW_RAM_SEND];
    assign ir_load  = ctrl[CW_IR_LOAD];
    assign ir_send  = ctrl[CW_IR_SEND];
    assign a_load   = ctrl[CW_A_LOAD];
    assign a_send   = ctrl[CW_A_SEND];
    assign b_load   = ctrl[CW_B_LOAD];
    assign alu_send = ctrl[CW_ALU_SEND];
    assign alu_sub  = ctrl[CW_ALU_SUB];
    assign out_load = ctrl[CW_OUT_LOAD];

    // Bit T_W of the state encoding is the HALT flag; the rest is the ring.
    assign state_bits = state;
    assign t_state    = rst ? '0 : state_bits[T_W-1:0];
    assign halted     = ~rst & state_bits[T_W];

    // debug only qualifies the bus-exclusivity assertion below.
    logic unused_debug;
    assign unused_debug = debug;

    send_exclusive: assert property (@(posedge clk) disable iff (!debug)
                                     $onehot0(ctrl & CW_SEND_MASK));

endmodule
